// File: rtl/seq_detector.sv
// Sliding-window serial pattern detector with a registered one-cycle detect pulse
// and a saturating, clearable hit counter. All outputs come straight from registers.
module seq_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PAT     = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     Rd,
    input  logic                     en,
    input  logic                     din,
    input  logic                     clr,
    output logic                     detect,
    output logic [$clog2(N+1)-1:0]   fill,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic                     cnt_sat
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       window_q, window_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic               cnt_sat_q, cnt_sat_d;

    logic [N-1:0]       shifted;
    logic [FW-1:0]      fill_inc;
    logic               match;

    always_ff @(posedge clk) begin
        if (Rd) begin
            state_q   <= EMPTY;
            window_q  <= '0;
            fill_q    <= '0;
            detect_q  <= 1'b0;
            hit_cnt_q <= '0;
            cnt_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            fill_q    <= fill_d;
            detect_q  <= detect_d;
            hit_cnt_q <= hit_cnt_d;
            cnt_sat_q <= cnt_sat_d;
        end
    end

    // Match is judged on the post-shift window and post-shift fill of this edge.
    always_comb begin
        shifted  = {window_q[N-2:0], din};
        fill_inc = (state_q == FULL) ? FILL_MAX : fill_q + 1'b1;
        match    = en && (shifted == PAT) && (fill_inc == FILL_MAX);
        window_d = window_q;
        fill_d   = fill_q;
        if (en) begin
            if (match && !OVERLAP) begin
                window_d = '0;
                fill_d   = '0;
            end else begin
                window_d = shifted;
                fill_d   = fill_inc;
            end
        end
        if (fill_d == '0)
            state_d = EMPTY;
        else if (fill_d == FILL_MAX)
            state_d = FULL;
        else
            state_d = FILLING;
    end

    // clr takes priority over a coincident match for the counter only.
    always_comb begin
        detect_d  = match;
        hit_cnt_d = hit_cnt_q;
        cnt_sat_d = cnt_sat_q;
        if (clr) begin
            hit_cnt_d = '0;
            cnt_sat_d = 1'b0;
        end else begin
            if (match && (hit_cnt_q != '1))
                hit_cnt_d = hit_cnt_q + 1'b1;
            if (hit_cnt_d == '1)
                cnt_sat_d = 1'b1;
        end
    end

    assign detect  = detect_q;
    assign fill    = fill_q;
    assign hit_cnt = hit_cnt_q;
    assign cnt_sat = cnt_sat_q;

endmodule
